// File: rtl/mem_arb_pkg.sv
// Shared encodings for the CPU/external memory arbiter.
package mem_arb_pkg;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_RDATA = 2'd2;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_EXT = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE  = S_IDLE,
    ST_ISSUE = S_ISSUE,
    ST_RDATA = S_RDATA
  } state_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant: on contention the port that was not served last wins.
module rr_arb2
  import mem_arb_pkg::*;
(
  input  logic req_cpu,
  input  logic req_ext,
  input  logic last,
  output logic gnt_valid,
  output logic gnt_id
);

  // Grant decode from the two requests and the round-robin pointer
  always_comb begin
    gnt_valid = req_cpu | req_ext;
    gnt_id    = PORT_CPU;
    if (req_cpu && req_ext) begin
      gnt_id = ~last;
    end else if (req_ext) begin
      gnt_id = PORT_EXT;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Serializes CPU and external-master accesses onto one single-port synchronous memory.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              ext_req,
  input  logic              ext_we,
  input  logic [ADDR_W-1:0] ext_addr,
  input  logic [DATA_W-1:0] ext_wdata,
  output logic              ext_ack,
  output logic [DATA_W-1:0] ext_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  state_e            state_q, state_d;
  logic              last_q, last_d;
  logic              gnt_q, gnt_d;
  logic              gnt_we_q, gnt_we_d;
  logic              mem_en_d, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_d;
  logic              cpu_ack_d, ext_ack_d;
  logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [DATA_W-1:0] ext_rdata_q, ext_rdata_d;

  logic              arb_valid;
  logic              arb_id;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  rr_arb2 u_rr_arb2 (
    .req_cpu   (cpu_req),
    .req_ext   (ext_req),
    .last      (last_q),
    .gnt_valid (arb_valid),
    .gnt_id    (arb_id)
  );

  // Request payload of the port the arbiter would grant this cycle
  always_comb begin
    sel_we    = cpu_we;
    sel_addr  = cpu_addr;
    sel_wdata = cpu_wdata;
    if (arb_id == PORT_EXT) begin
      sel_we    = ext_we;
      sel_addr  = ext_addr;
      sel_wdata = ext_wdata;
    end
  end

  // Next-state and next-output decode; pulses default low, everything else holds
  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    gnt_d       = gnt_q;
    gnt_we_d    = gnt_we_q;
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr;
    mem_wdata_d = mem_wdata;
    cpu_ack_d   = 1'b0;
    ext_ack_d   = 1'b0;
    cpu_rdata_d = cpu_rdata_q;
    ext_rdata_d = ext_rdata_q;
    unique case (state_q)
      ST_IDLE: begin
        if (arb_valid) begin
          state_d     = ST_ISSUE;
          last_d      = arb_id;
          gnt_d       = arb_id;
          gnt_we_d    = sel_we;
          mem_en_d    = 1'b1;
          mem_we_d    = sel_we;
          mem_addr_d  = sel_addr;
          mem_wdata_d = sel_wdata;
          // Writes complete in the ISSUE cycle, so their ack is loaded now
          if (sel_we) begin
            cpu_ack_d = (arb_id == PORT_CPU);
            ext_ack_d = (arb_id == PORT_EXT);
          end
        end
      end
      ST_ISSUE: begin
        if (gnt_we_q) begin
          state_d = ST_IDLE;
        end else begin
          state_d   = ST_RDATA;
          cpu_ack_d = (gnt_q == PORT_CPU);
          ext_ack_d = (gnt_q == PORT_EXT);
        end
      end
      ST_RDATA: begin
        state_d = ST_IDLE;
        if (gnt_q == PORT_CPU) begin
          cpu_rdata_d = mem_rdata;
        end else begin
          ext_rdata_d = mem_rdata;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      last_q      <= PORT_EXT;
      gnt_q       <= PORT_CPU;
      gnt_we_q    <= 1'b0;
      mem_en      <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      cpu_ack     <= 1'b0;
      ext_ack     <= 1'b0;
      cpu_rdata_q <= '0;
      ext_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      gnt_q       <= gnt_d;
      gnt_we_q    <= gnt_we_d;
      mem_en      <= mem_en_d;
      mem_we      <= mem_we_d;
      mem_addr    <= mem_addr_d;
      mem_wdata   <= mem_wdata_d;
      cpu_ack     <= cpu_ack_d;
      ext_ack     <= ext_ack_d;
      cpu_rdata_q <= cpu_rdata_d;
      ext_rdata_q <= ext_rdata_d;
    end
  end

  // Memory read data is only valid in RDATA, so it passes straight through then and is held after
  assign cpu_rdata = (state_q == ST_RDATA && gnt_q == PORT_CPU) ? mem_rdata : cpu_rdata_q;
  assign ext_rdata = (state_q == ST_RDATA && gnt_q == PORT_EXT) ? mem_rdata : ext_rdata_q;

  // Stall holds the CPU state register until its own ack arrives
  assign cpu_stall = cpu_req & ~cpu_ack;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter with a small synchronous memory model.
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;

  logic              clk = 1'b0;
  logic              reset;
  logic              cpu_req, cpu_we, ext_req, ext_we;
  logic [ADDR_W-1:0] cpu_addr, ext_addr, mem_addr;
  logic [DATA_W-1:0] cpu_wdata, ext_wdata, mem_wdata, mem_rdata;
  logic              cpu_ack, ext_ack, cpu_stall, mem_en, mem_we;
  logic [DATA_W-1:0] cpu_rdata, ext_rdata;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct packed {
    logic        port;
    logic        is_read;
    logic [31:0] data;
  } exp_t;
  exp_t sb_q[$];
  exp_t sb_e;
  logic        got_port;
  logic [31:0] got_data;

  logic [31:0] mem [256];

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_ack   (cpu_ack),
    .cpu_rdata (cpu_rdata),
    .cpu_stall (cpu_stall),
    .ext_req   (ext_req),
    .ext_we    (ext_we),
    .ext_addr  (ext_addr),
    .ext_wdata (ext_wdata),
    .ext_ack   (ext_ack),
    .ext_rdata (ext_rdata),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  function automatic logic [31:0] init_val(int unsigned i);
    return (i == 16) ? 32'hDEAD_BEEF : (32'hA5A5_0000 | 32'(i));
  endfunction

  // Single-port synchronous memory; reset reloads known contents
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 256; i++) mem[i] <= init_val(i);
      mem_rdata <= '0;
    end else if (mem_en) begin
      if (mem_we) mem[mem_addr[9:2]] <= mem_wdata;
      else        mem_rdata <= mem[mem_addr[9:2]];
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic port, input logic is_read, input logic [31:0] data);
    exp_t e;
    e.port = port; e.is_read = is_read; e.data = data;
    sb_q.push_back(e);
  endtask

  task automatic do_reset();
    reset = 1'b1; cpu_req = 1'b0; ext_req = 1'b0;
    repeat (2) tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; cpu_req = 1'b0; ext_req = 1'b0; cpu_we = 1'b0; ext_we = 1'b0;
    cpu_addr = '0; ext_addr = '0; cpu_wdata = '0; ext_wdata = '0;
    repeat (2) tick();
    @(negedge clk);
    n_tests++;
    if ({mem_en, mem_we, cpu_ack, ext_ack, cpu_stall} !== 5'b0) begin
      n_fail++; $display("FAIL reset_ctrl: got %b want 00000", {mem_en, mem_we, cpu_ack, ext_ack, cpu_stall});
    end
    n_tests++;
    if ({mem_addr, mem_wdata, cpu_rdata, ext_rdata} !== 128'h0) begin
      n_fail++; $display("FAIL reset_data: addr=%h wdata=%h crd=%h erd=%h want 0", mem_addr, mem_wdata, cpu_rdata, ext_rdata);
    end
    tick();
    reset = 1'b0;
  endtask

  task automatic test_cpu_read();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h40;
    push(PORT_CPU, 1'b1, 32'hDEAD_BEEF);
    @(negedge clk);
    n_tests++;
    if ({cpu_stall, mem_en} !== 2'b10) begin
      n_fail++; $display("FAIL rd_cycle0: stall,en got %b want 10", {cpu_stall, mem_en});
    end
    tick();
    @(negedge clk);
    n_tests++;
    if ({mem_en, mem_we, cpu_stall, cpu_ack} !== 4'b1010 || mem_addr !== 32'h40) begin
      n_fail++; $display("FAIL rd_cycle1: en,we,stall,ack got %b addr %h want 1010 addr 40", {mem_en, mem_we, cpu_stall, cpu_ack}, mem_addr);
    end
    tick();
    @(negedge clk);
    n_tests++;
    if ({cpu_ack, cpu_stall} !== 2'b10 || cpu_rdata !== 32'hDEAD_BEEF) begin
      n_fail++; $display("FAIL rd_cycle2: ack,stall got %b rdata %h want 10 deadbeef", {cpu_ack, cpu_stall}, cpu_rdata);
    end
    tick();
    cpu_req = 1'b0;
    @(negedge clk);
    n_tests++;
    if (cpu_ack !== 1'b0 || cpu_rdata !== 32'hDEAD_BEEF) begin
      n_fail++; $display("FAIL rd_hold: ack %b rdata %h want 0 deadbeef", cpu_ack, cpu_rdata);
    end
    tick();
  endtask

  task automatic test_cpu_write();
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h10; cpu_wdata = 32'h1234;
    push(PORT_CPU, 1'b0, 32'h0);
    tick();
    @(negedge clk);
    n_tests++;
    if ({mem_en, mem_we, cpu_ack, cpu_stall} !== 4'b1110 || mem_wdata !== 32'h1234) begin
      n_fail++; $display("FAIL wr_cycle1: en,we,ack,stall got %b wdata %h want 1110 1234", {mem_en, mem_we, cpu_ack, cpu_stall}, mem_wdata);
    end
    tick();
    cpu_req = 1'b0;
    @(negedge clk);
    n_tests++;
    if ({mem_en, cpu_ack} !== 2'b00) begin
      n_fail++; $display("FAIL wr_idle: en,ack got %b want 00", {mem_en, cpu_ack});
    end
    tick();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h10;
    push(PORT_CPU, 1'b1, 32'h1234);
    repeat (2) tick();
    @(negedge clk);
    n_tests++;
    if (cpu_ack !== 1'b1 || cpu_rdata !== 32'h1234) begin
      n_fail++; $display("FAIL wr_readback: ack %b rdata %h want 1 1234", cpu_ack, cpu_rdata);
    end
    tick();
    cpu_req = 1'b0;
    tick();
  endtask

  task automatic test_contention();
    do_reset();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h40;
    ext_req = 1'b1; ext_we = 1'b0; ext_addr = 32'h80;
    push(PORT_CPU, 1'b1, 32'hDEAD_BEEF);
    push(PORT_EXT, 1'b1, init_val(32));
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      n_tests++;
      if ({cpu_ack, ext_ack, mem_en} !== {1'(c == 2), 1'(c == 5), 1'(c == 1 || c == 4)}) begin
        n_fail++; $display("FAIL contend_c%0d: cpu_ack,ext_ack,en got %b want %b", c, {cpu_ack, ext_ack, mem_en}, {1'(c == 2), 1'(c == 5), 1'(c == 1 || c == 4)});
      end
      if (c == 4) begin
        n_tests++;
        if (mem_addr !== 32'h80) begin
          n_fail++; $display("FAIL contend_ext_addr: got %h want 80", mem_addr);
        end
      end
      tick();
      if (c == 2) cpu_req = 1'b0;
      if (c == 5) ext_req = 1'b0;
    end
  endtask

  task automatic test_round_robin();
    int cpu_cnt = 0;
    int ext_cnt = 0;
    int last_ack = -1;
    do_reset();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h40;
    ext_req = 1'b1; ext_we = 1'b0; ext_addr = 32'h44;
    for (int k = 0; k < 3; k++) begin
      push(PORT_CPU, 1'b1, 32'hDEAD_BEEF);
      push(PORT_EXT, 1'b1, init_val(17));
    end
    for (int c = 0; c < 40 && (cpu_cnt < 3 || ext_cnt < 3); c++) begin
      @(negedge clk);
      if (cpu_ack) begin cpu_cnt++; last_ack = c; end
      if (ext_ack) begin ext_cnt++; last_ack = c; end
      tick();
      if (cpu_cnt == 3) cpu_req = 1'b0;
      if (ext_cnt == 3) ext_req = 1'b0;
    end
    cpu_req = 1'b0; ext_req = 1'b0;
    n_tests++;
    if (cpu_cnt != 3 || ext_cnt != 3 || last_ack != 17) begin
      n_fail++; $display("FAIL rr_count: cpu %0d ext %0d last_ack_cycle %0d want 3 3 17", cpu_cnt, ext_cnt, last_ack);
    end
    tick();
  endtask

  task automatic test_reset_mid_read();
    do_reset();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h40;
    tick();
    @(negedge clk);
    n_tests++;
    if (mem_en !== 1'b1) begin
      n_fail++; $display("FAIL rmr_issue: en got %b want 1", mem_en);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0; cpu_req = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_tests++;
      if ({cpu_ack, ext_ack, mem_en} !== 3'b000) begin
        n_fail++; $display("FAIL rmr_quiet_c%0d: acks,en got %b want 000", c, {cpu_ack, ext_ack, mem_en});
      end
      tick();
    end
    cpu_req = 1'b1; ext_req = 1'b1; ext_we = 1'b0; ext_addr = 32'h80;
    push(PORT_CPU, 1'b1, 32'hDEAD_BEEF);
    push(PORT_EXT, 1'b1, init_val(32));
    repeat (2) tick();
    @(negedge clk);
    n_tests++;
    if ({cpu_ack, ext_ack} !== 2'b10) begin
      n_fail++; $display("FAIL rmr_first_grant: cpu,ext ack got %b want 10", {cpu_ack, ext_ack});
    end
    tick();
    cpu_req = 1'b0;
    repeat (3) tick();
    ext_req = 1'b0;
    tick();
  endtask

  task automatic test_ext_write_during_stall();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h40;
    push(PORT_CPU, 1'b1, 32'hDEAD_BEEF);
    push(PORT_EXT, 1'b0, 32'h0);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      n_tests++;
      if ({cpu_ack, ext_ack, mem_we, cpu_stall} !== {1'(c == 2), 1'(c == 4), 1'(c == 4), 1'(c < 2)}) begin
        n_fail++; $display("FAIL extwr_c%0d: cack,eack,we,stall got %b want %b", c, {cpu_ack, ext_ack, mem_we, cpu_stall}, {1'(c == 2), 1'(c == 4), 1'(c == 4), 1'(c < 2)});
      end
      tick();
      if (c == 0) begin ext_req = 1'b1; ext_we = 1'b1; ext_addr = 32'h80; ext_wdata = 32'hAA; end
      if (c == 2) cpu_req = 1'b0;
      if (c == 4) ext_req = 1'b0;
    end
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h80;
    push(PORT_CPU, 1'b1, 32'hAA);
    repeat (2) tick();
    @(negedge clk);
    n_tests++;
    if (cpu_ack !== 1'b1 || cpu_rdata !== 32'hAA) begin
      n_fail++; $display("FAIL extwr_readback: ack %b rdata %h want 1 000000aa", cpu_ack, cpu_rdata);
    end
    tick();
    cpu_req = 1'b0;
    repeat (2) tick();
  endtask

  initial begin
    reset = 1'b1; cpu_req = 1'b0; ext_req = 1'b0;
    fork
      // Scoreboard monitor: every ack pops the next expected transaction
      forever begin
        @(negedge clk);
        if (!reset && (cpu_ack || ext_ack)) begin
          n_tests++;
          if (cpu_ack && ext_ack) begin
            n_fail++; $display("FAIL sb_dual_ack: cpu_ack=%b ext_ack=%b want only one", cpu_ack, ext_ack);
          end else if (sb_q.size() == 0) begin
            n_fail++; $display("FAIL sb_unexpected_ack: cpu_ack=%b ext_ack=%b want none", cpu_ack, ext_ack);
          end else begin
            sb_e     = sb_q.pop_front();
            got_port = ext_ack;
            got_data = ext_ack ? ext_rdata : cpu_rdata;
            if (got_port !== sb_e.port || (sb_e.is_read && got_data !== sb_e.data)) begin
              n_fail++; $display("FAIL sb_ack: port %b data %h want port %b data %h", got_port, got_data, sb_e.port, sb_e.data);
            end
          end
        end
      end
    join_none
    test_reset();
    test_cpu_read();
    test_cpu_write();
    test_contention();
    test_round_robin();
    test_reset_mid_read();
    test_ext_write_during_stall();
    n_tests++;
    if (sb_q.size() != 0) begin
      n_fail++; $display("FAIL sb_leftover: %0d pending want 0", sb_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Arbiter placed between the multi-cycle CPU's unified instruction/data memory port and an external master, such as a boot loader or debug DMA, that must share the single-port synchronous memory. It serializes requests from both masters with a two-way round-robin policy and runs each memory transaction through a small state machine. It also raises a stall to the CPU controller so the CPU state register holds until its access completes.

## Interface
Parameters:
- ADDR_W, 32, byte-address width on both requester ports and the memory port
- DATA_W, 32, data width

Ports:
- Clock and reset (already decided): one clock, `clk`; `reset` is synchronous and active-high.
- clk  input  1  single clock; all state changes on its rising edge
- reset  input  1  synchronous, active-high
- cpu_req  input  1  CPU access request; held high until cpu_ack
- cpu_we  input  1  1 = write, 0 = read; stable while cpu_req is high
- cpu_addr  input  ADDR_W  CPU address; stable while cpu_req is high
- cpu_wdata  input  DATA_W  CPU write data
- cpu_ack  output  1  one-cycle completion pulse
- cpu_rdata  output  DATA_W  read data, valid in the cpu_ack cycle
- cpu_stall  output  1  cpu_req & ~cpu_ack, combinational
- ext_req, ext_we, ext_addr, ext_wdata, ext_ack, ext_rdata: same meaning for the external master
- mem_en  output  1  memory enable, registered
- mem_we  output  1  memory write enable, registered
- mem_addr  output  ADDR_W  registered
- mem_wdata  output  DATA_W  registered
- mem_rdata  input  DATA_W  memory read data, valid one cycle after mem_en with mem_we = 0

## Operation
- States:
  - IDLE: no transaction in progress.
  - ISSUE: memory is driven.
  - RDATA: read data is returned.
- IDLE:
  - Arbitration samples cpu_req and ext_req.
  - Only one request high: that port is granted.
  - Both high: the port that is not `last` is granted.
  - On grant, the mem_* registers load from the granted port, `last` is updated to the granted port, and the next state is ISSUE.
  - No request: remain in IDLE.
- ISSUE:
  - mem_en = 1 and mem_we = the granted port's we.
  - Write: the granted ack is asserted this cycle; next state is IDLE.
  - Read: next state is RDATA.
- RDATA:
  - Granted ack = 1 and granted rdata = mem_rdata; next state is IDLE.
  - rdata outputs hold their last value outside ack cycles.
- Requester rule: after seeing ack, a requester must deassert req in the next cycle or present a new request. The mandatory IDLE cycle after every transaction makes any req sampled there a fresh request.
- The round-robin pointer `last` resets to EXT, so the CPU wins the first contended grant.
- The non-granted port's ack stays 0. Its request stays pending with no loss.
- A requester that drops req mid-transaction is a protocol violation. The transaction still completes to memory and ack is still pulsed.
- Synchronous reset in any state:
  - Next cycle is IDLE with mem_en = mem_we = 0 and both acks = 0.
  - mem_addr, mem_wdata, cpu_rdata and ext_rdata are 0.
  - `last` = EXT.
  - An in-flight transaction is abandoned with no ack.

## Timing
- Req sampled high in IDLE at edge k:
  - ISSUE in cycle k+1.
  - Write ack in cycle k+1.
  - Read ack and data in cycle k+2.
- Write occupancy is 2 cycles (IDLE, ISSUE); read occupancy is 3 cycles (IDLE, ISSUE, RDATA).
- Worst-case wait for a contended CPU read is one external read plus its own read: 6 cycles.
- cpu_stall is combinational. It is high from the first cycle cpu_req is high through the cycle before cpu_ack.
- All outputs except cpu_stall are registered or decoded from state only; there is no combinational path from req to ack.

## Structure
- Shared package `mem_arb_pkg`:
  - state encoding localparams S_IDLE, S_ISSUE, S_RDATA (2 bits)
  - port IDs PORT_CPU = 0, PORT_EXT = 1
- Sub-module `rr_arb2`:
  - inputs: two requests and `last`
  - outputs: grant valid and grant ID
  - purely combinational
- Top level holds the FSM, `last`, the granted-port register and the mem_*/rdata registers; 150–250 lines total.

## Test plan
- CPU read alone: mem[0x40] = 0xDEADBEEF, cpu_req with cpu_addr = 0x40 at edge 0 -> mem_en = 1 in cycle 1; cpu_ack = 1 with cpu_rdata = 0xDEADBEEF in cycle 2; cpu_stall high in cycles 0–1.
- CPU write: cpu_we = 1, cpu_addr = 0x10, cpu_wdata = 0x1234 -> mem_we = 1 and cpu_ack = 1 in cycle 1; a later read of 0x10 returns 0x1234.
- Contention after reset: both ports request reads at edge 0 -> CPU acked in cycle 2; IDLE in cycle 3; EXT ISSUE in cycle 4; EXT acked in cycle 5.
- Round-robin fairness: both ports hold back-to-back requests for 6 transactions -> grant order CPU, EXT, CPU, EXT, CPU, EXT; no ack is ever asserted to the waiting port.
- Reset mid-read: reset asserted in the ISSUE cycle -> next cycle IDLE, no ack pulses, mem_en = 0; a subsequent contended request goes to the CPU first.
- Ext write during CPU stall: EXT writes 0xAA to 0x80 while the CPU is in a read -> the CPU read completes first; the EXT write follows 1 cycle later through IDLE; cpu_stall stays low after cpu_ack.
